// File: rtl/haddoc_ocm_pkg.sv
// ============================================================================
// haddoc_ocm_pkg : constants and state type shared by the OCM reader/writer
// Rev 1.0
// ============================================================================
`default_nettype none

package haddoc_ocm_pkg;

    localparam int OCM_ADDR_W = 17;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = 784;
    localparam int NB_CLASSES = 10;
    localparam int ARGMAX_W   = 7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        WAIT_DV = 3'd2,
        WRITE   = 3'd3,
        STATUS  = 3'd4,
        DONE    = 3'd5
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/running_argmax.sv
// ============================================================================
// running_argmax : tracks index of the largest signed value seen since clr
// Rev 1.0
// ============================================================================
`default_nettype none

module running_argmax #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [DATA_W-1:0] value,
    output logic [IDX_W-1:0]         best_idx
);

    logic signed [DATA_W-1:0] r_best_val;

    // clr together with en seeds the search with the first element of a vector;
    // strict '>' keeps the lower index on ties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_idx   <= '0;
            r_best_val <= '0;
        end else if (clr) begin
            best_idx   <= en ? idx : '0;
            r_best_val <= en ? value : '0;
        end else if (en && (value > r_best_val)) begin
            best_idx   <= idx;
            r_best_val <= value;
        end
    end

endmodule

`default_nettype wire

// File: rtl/haddoc_result_writer.sv
// ============================================================================
// haddoc_result_writer : serialises CNN result vectors + status byte into OCM1
// Rev 1.0
// ============================================================================
`default_nettype none

module haddoc_result_writer
    import haddoc_ocm_pkg::*;
#(
    parameter int          NB_OUT     = NB_CLASSES,
    parameter int          DATA_W     = PIX_W,
    parameter int          ADDR_W     = OCM_ADDR_W,
    parameter int          NB_VECTORS = 1,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     finish,
    output logic                     busy,
    output logic                     overflow,
    output logic [ARGMAX_W-1:0]      argmax,
    input  logic [NB_OUT*DATA_W-1:0] in_data,
    input  logic                     in_dv,
    output logic [ADDR_W-1:0]        ocm1_addr,
    output logic [DATA_W-1:0]        ocm1_writedata,
    output logic                     ocm1_chip,
    output logic                     ocm1_clk_enab,
    output logic                     ocm1_write
);

    localparam int c_VEC_W  = $clog2(NB_VECTORS + 1);
    localparam int c_ELEM_W = $clog2(NB_OUT + 1);
    localparam logic [c_ELEM_W-1:0] c_LAST_ELEM   = c_ELEM_W'(NB_OUT - 1);
    localparam logic [c_VEC_W-1:0]  c_LAST_VEC    = c_VEC_W'(NB_VECTORS - 1);
    localparam logic [ADDR_W-1:0]   c_BASE        = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]   c_STATUS_ADDR = ADDR_W'(BASE_ADDR + NB_VECTORS * NB_OUT);

    wr_state_t                 r_state, w_state_nx;
    logic [c_VEC_W-1:0]        r_vec_cnt, w_vec_nx;
    logic [c_ELEM_W-1:0]       r_elem_cnt, w_elem_nx;
    logic [NB_OUT*DATA_W-1:0]  r_capture, w_src;
    logic [DATA_W-1:0]         w_chan;
    logic [ADDR_W-1:0]         w_addr_nx;
    logic [7:0]                w_status8;
    logic [ARGMAX_W-1:0]       w_best_idx, w_argmax_nx;
    logic                      w_overflow_nx, w_vec_done;

    always_comb begin
        w_state_nx = r_state;
        w_vec_nx   = r_vec_cnt;
        w_elem_nx  = r_elem_cnt;
        unique case (r_state)
            IDLE:    if (start) w_state_nx = ARM;
            ARM: begin
                w_vec_nx   = '0;
                w_elem_nx  = '0;
                w_state_nx = start ? WAIT_DV : IDLE;
            end
            WAIT_DV: begin
                if (!start) begin
                    w_state_nx = IDLE;
                end else if (in_dv) begin
                    w_state_nx = WRITE;
                    w_elem_nx  = '0;
                end
            end
            WRITE: begin
                if (!start) begin
                    w_state_nx = IDLE;
                end else if (r_elem_cnt == c_LAST_ELEM) begin
                    w_vec_nx   = r_vec_cnt + 1'b1;
                    w_state_nx = (r_vec_cnt == c_LAST_VEC) ? STATUS : WAIT_DV;
                end else begin
                    w_elem_nx  = r_elem_cnt + 1'b1;
                end
            end
            STATUS:  w_state_nx = DONE;
            DONE:    if (!start) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so each edge loads what the next state presents;
    // element 0 is taken straight from in_data because capture is loading in parallel.
    assign w_src      = (r_state == WAIT_DV) ? in_data : r_capture;
    assign w_chan     = w_src[int'(w_elem_nx) * DATA_W +: DATA_W];
    assign w_addr_nx  = c_BASE + ADDR_W'(w_vec_nx) * ADDR_W'(NB_OUT) + ADDR_W'(w_elem_nx);
    assign w_vec_done = (r_state == WRITE) && start && (r_elem_cnt == c_LAST_ELEM);

    always_comb begin
        w_overflow_nx = overflow;
        if (w_state_nx == ARM)
            w_overflow_nx = 1'b0;
        else if (in_dv && ((r_state == WRITE) || (r_state == STATUS)))
            w_overflow_nx = 1'b1;

        w_argmax_nx = argmax;
        if (w_state_nx == ARM)
            w_argmax_nx = '0;
        else if (w_vec_done)
            w_argmax_nx = w_best_idx;
    end

    assign w_status8 = {w_overflow_nx, w_argmax_nx};

    running_argmax #(
        .DATA_W (DATA_W),
        .IDX_W  (ARGMAX_W)
    ) u_argmax (
        .clk      (clk),
        .reset    (reset),
        .clr      ((w_state_nx == ARM) || ((w_state_nx == WRITE) && (w_elem_nx == '0))),
        .en       (w_state_nx == WRITE),
        .idx      (ARGMAX_W'(w_elem_nx)),
        .value    (w_chan),
        .best_idx (w_best_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_vec_cnt      <= '0;
            r_elem_cnt     <= '0;
            r_capture      <= '0;
            overflow       <= 1'b0;
            argmax         <= '0;
            finish         <= 1'b0;
            busy           <= 1'b0;
            ocm1_addr      <= '0;
            ocm1_writedata <= '0;
            ocm1_chip      <= 1'b0;
            ocm1_clk_enab  <= 1'b0;
            ocm1_write     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_vec_cnt  <= w_vec_nx;
            r_elem_cnt <= w_elem_nx;
            overflow   <= w_overflow_nx;
            argmax     <= w_argmax_nx;
            if ((r_state == WAIT_DV) && in_dv)
                r_capture <= in_data;
            finish <= (w_state_nx == DONE);
            busy   <= (w_state_nx inside {ARM, WAIT_DV, WRITE, STATUS});
            ocm1_chip     <= (w_state_nx inside {WRITE, STATUS});
            ocm1_clk_enab <= (w_state_nx inside {WRITE, STATUS});
            ocm1_write    <= (w_state_nx inside {WRITE, STATUS});
            if (w_state_nx == STATUS) begin
                ocm1_addr      <= c_STATUS_ADDR;
                ocm1_writedata <= DATA_W'(w_status8);
            end else if (w_state_nx == WRITE) begin
                ocm1_addr      <= w_addr_nx;
                ocm1_writedata <= w_chan;
            end else begin
                ocm1_addr      <= '0;
                ocm1_writedata <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_haddoc_result_writer.sv
// ============================================================================
// tb_haddoc_result_writer : directed/random runs checked against a write-list model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_haddoc_result_writer;

    localparam int NB_OUT     = 10;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 17;
    localparam int NB_VECTORS = 2;
    localparam int BASE       = 32'h100;

    logic                     clk = 1'b0;
    logic                     reset, start, in_dv;
    logic [NB_OUT*DATA_W-1:0] in_data;
    logic                     finish, busy, overflow;
    logic [6:0]               argmax;
    logic [ADDR_W-1:0]        ocm1_addr;
    logic [DATA_W-1:0]        ocm1_writedata;
    logic                     ocm1_chip, ocm1_clk_enab, ocm1_write;

    haddoc_result_writer #(
        .NB_OUT     (NB_OUT),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .NB_VECTORS (NB_VECTORS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .finish         (finish),
        .busy           (busy),
        .overflow       (overflow),
        .argmax         (argmax),
        .in_data        (in_data),
        .in_dv          (in_dv),
        .ocm1_addr      (ocm1_addr),
        .ocm1_writedata (ocm1_writedata),
        .ocm1_chip      (ocm1_chip),
        .ocm1_clk_enab  (ocm1_clk_enab),
        .ocm1_write     (ocm1_write)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int bad_strobe = 0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [7:0]        obs_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [7:0]        exp_data[$];

    // Record every RAM write, and flag any cycle where the three strobes disagree.
    always @(negedge clk) begin
        if (ocm1_write === 1'b1) begin
            obs_addr.push_back(ocm1_addr);
            obs_data.push_back(ocm1_writedata);
        end
        if ((ocm1_chip !== ocm1_write) || (ocm1_clk_enab !== ocm1_write))
            bad_strobe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ch(input logic [79:0] v, input int i);
        return v[i*8 +: 8];
    endfunction

    function automatic int ref_argmax(input logic [79:0] v);
        int best = 0;
        for (int i = 1; i < NB_OUT; i++)
            if ($signed(ch(v, i)) > $signed(ch(v, best))) best = i;
        return best;
    endfunction

    // Narrow value range so ties occur often.
    function automatic logic [79:0] rand_vec();
        logic [79:0] v;
        for (int i = 0; i < NB_OUT; i++)
            v[i*8 +: 8] = 8'($urandom_range(0, 15)) - 8'd8;
        return v;
    endfunction

    task automatic send(input logic [79:0] v);
        in_data = v;
        in_dv   = 1'b1;
        tick(1);
        in_dv   = 1'b0;
        in_data = 80'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic exp_vec(input logic [79:0] v, input int vi, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(ADDR_W'(BASE + vi * NB_OUT + i));
            exp_data.push_back(ch(v, i));
        end
    endtask

    task automatic exp_status(input bit ovf, input int am);
        exp_addr.push_back(ADDR_W'(BASE + NB_VECTORS * NB_OUT));
        exp_data.push_back({ovf, 7'(am)});
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_count"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s_data%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
        end
        obs_addr.delete(); obs_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic wait_finish(input string tag);
        int n = 0;
        while ((finish !== 1'b1) && (n < 200)) begin
            tick(1);
            n++;
        end
        chk({tag, "_finish"}, 32'(finish), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ctrl"}, {22'd0, finish, busy, overflow, argmax}, 32'd0);
        chk({tag, "_ocm"}, {4'd0, ocm1_addr, ocm1_writedata, ocm1_chip, ocm1_clk_enab, ocm1_write}, 32'd0);
    endtask

    logic [79:0] va, vb, vc;

    initial begin
        reset = 1'b1; start = 1'b0; in_dv = 1'b0; in_data = '0;
        tick(2);
        check_quiet("reset");
        reset = 1'b0;
        tick(1);

        // Two vectors 20 cycles apart, first one the fixed reference vector.
        va = {8'd4, 8'd6, 8'd2, 8'h80, 8'd0, 8'd1, 8'd7, 8'd7, 8'hFB, 8'd3};
        vb = rand_vec();
        start = 1'b1;
        tick(2);
        chk("arm_busy", 32'(busy), 32'd1);
        send(va);
        @(negedge clk);
        chk("first_write_latency", {14'd0, ocm1_write, ocm1_addr}, {14'd0, 1'b1, 17'(BASE)});
        chk("first_write_data", 32'(ocm1_writedata), 32'd3);
        tick(11);
        chk("argmax_vec0", 32'(argmax), 32'd2);
        chk("no_finish_mid", 32'(finish), 32'd0);
        tick(8);
        send(vb);
        wait_finish("run1");
        chk("run1_busy", 32'(busy), 32'd0);
        chk("run1_argmax", 32'(argmax), 32'(ref_argmax(vb)));
        chk("run1_overflow", 32'(overflow), 32'd0);
        exp_vec(va, 0, NB_OUT); exp_vec(vb, 1, NB_OUT); exp_status(1'b0, ref_argmax(vb));
        cmp_writes("run1");
        tick(3);
        chk("done_hold", 32'(finish), 32'd1);
        start = 1'b0;
        tick(1);
        chk("finish_drop", 32'(finish), 32'd0);

        // Second in_dv three cycles after the first is dropped.
        va = rand_vec(); vb = rand_vec();
        start = 1'b1;
        tick(2);
        send(va);
        tick(2);
        send(rand_vec());
        tick(1);
        chk("ovf_set", 32'(overflow), 32'd1);
        tick(14);
        send(vb);
        wait_finish("run2");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        exp_vec(va, 0, NB_OUT); exp_vec(vb, 1, NB_OUT); exp_status(1'b1, ref_argmax(vb));
        cmp_writes("run2");
        start = 1'b0;
        tick(1);

        // in_dv landing in the cycle of the final element write still counts.
        va = rand_vec(); vb = rand_vec();
        start = 1'b1;
        tick(2);
        chk("arm_clears_ovf", 32'(overflow), 32'd0);
        send(va);
        tick(15);
        send(vb);
        tick(9);
        in_dv = 1'b1;
        tick(1);
        in_dv = 1'b0;
        wait_finish("run3");
        chk("ovf_last_elem", 32'(overflow), 32'd1);
        exp_vec(va, 0, NB_OUT); exp_vec(vb, 1, NB_OUT); exp_status(1'b1, ref_argmax(vb));
        cmp_writes("run3");
        start = 1'b0;
        tick(1);

        // Abort during element 4, then stray in_dv while idle.
        va = rand_vec();
        start = 1'b1;
        tick(2);
        send(va);
        tick(4);
        start = 1'b0;
        tick(1);
        chk("abort_quiet", {28'd0, busy, ocm1_write, ocm1_chip, ocm1_clk_enab}, 32'd0);
        tick(5);
        chk("abort_no_finish", 32'(finish), 32'd0);
        exp_vec(va, 0, 5);
        cmp_writes("abort");
        send(rand_vec());
        tick(3);
        chk("idle_dv_ovf", 32'(overflow), 32'd0);
        cmp_writes("idle_dv");

        // Clean restart; all-equal -128 vector must report index 0.
        va = {10{8'h80}}; vb = rand_vec();
        start = 1'b1;
        tick(2);
        send(va);
        tick(11);
        chk("argmax_all_equal", 32'(argmax), 32'd0);
        send(vb);
        wait_finish("run4");
        exp_vec(va, 0, NB_OUT); exp_vec(vb, 1, NB_OUT); exp_status(1'b0, ref_argmax(vb));
        cmp_writes("run4");
        tick(4);
        chk("done_hold2", 32'(finish), 32'd1);
        start = 1'b0;
        tick(1);
        chk("finish_drop2", 32'(finish), 32'd0);

        // Asynchronous reset between edges while writing.
        va = rand_vec();
        start = 1'b1;
        tick(2);
        send(va);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("async_reset");
        start = 1'b0;
        #2;
        reset = 1'b0;
        tick(1);
        exp_vec(va, 0, 3);
        cmp_writes("pre_reset");

        va = rand_vec(); vb = rand_vec();
        start = 1'b1;
        tick(2);
        chk("rerun_busy", 32'(busy), 32'd1);
        send(va);
        tick(12);
        send(vb);
        wait_finish("run5");
        chk("run5_argmax", 32'(argmax), 32'(ref_argmax(vb)));
        exp_vec(va, 0, NB_OUT); exp_vec(vb, 1, NB_OUT); exp_status(1'b0, ref_argmax(vb));
        cmp_writes("run5");
        start = 1'b0;
        tick(2);
        chk("strobe_consistency", 32'(bad_strobe), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
